// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio output path: frame geometry,
// serial-format encodings and the system-clock to bit-clock divider derivation.
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;

  localparam int LJ_MODE_I2S = 0;  // Philips: one-bit delay, lrclk low = left
  localparam int LJ_MODE_LJ  = 1;  // left-justified: no delay, lrclk high = left

  function automatic int calc_div(input int clk_rate, input int audio_rate);
    return clk_rate / (FRAME_BITS * audio_rate);
  endfunction

  // The divider must be exact and even so both sclk half-periods are equal.
  function automatic bit div_valid(input int clk_rate, input int audio_rate);
    int div;
    div = calc_div(clk_rate, audio_rate);
    return (audio_rate > 0) && (clk_rate % (FRAME_BITS * audio_rate) == 0) &&
           (div >= 2) && (div % 2 == 0);
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock generator: toggles sclk every DIV/2 system clocks and flags the
// clk edge on which sclk falls, which paces all serializer updates.
module i2s_sclk_gen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic sclk_o,
  output logic fall_evt_o
);

  localparam int HALF   = DIV / 2;
  localparam int HCNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HCNT_W-1:0] HCNT_TC = HCNT_W'(HALF - 1);

  logic [HCNT_W-1:0] hcnt_q;
  logic              sclk_q;
  logic              tc;

  assign tc = (hcnt_q == HCNT_TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      sclk_q <= 1'b0;
    end else if (tc) begin
      hcnt_q <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      hcnt_q <= hcnt_q + 1'b1;
    end
  end

  assign sclk_o     = sclk_q;
  assign fall_evt_o = tc & sclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo 16-bit I2S / left-justified transmitter. Latches both channels once
// per 64-bit frame and emits sample_ce as the audio-rate enable for producers.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_RATE   = 24576000,
  parameter int AUDIO_RATE = 48000,
  parameter int LJ_MODE    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic        mute,
  output logic        sample_ce,
  output logic        sclk,
  output logic        lrclk,
  output logic        sdata
);

  localparam int   DIV    = calc_div(CLK_RATE, AUDIO_RATE);
  localparam logic LR_RST = (LJ_MODE == LJ_MODE_LJ) ? 1'b1 : 1'b0;

  if (!div_valid(CLK_RATE, AUDIO_RATE)) begin : g_bad_div
    $error("i2s_tx: CLK_RATE/(64*AUDIO_RATE) must be an even integer >= 2");
  end
  if (LJ_MODE != LJ_MODE_I2S && LJ_MODE != LJ_MODE_LJ) begin : g_bad_mode
    $error("i2s_tx: LJ_MODE must be 0 or 1");
  end

  logic                fall_evt;
  logic [5:0]          slot_q, slot_d;
  logic [SAMPLE_W-1:0] shift_l_q, shift_l_d;
  logic [SAMPLE_W-1:0] shift_r_q, shift_r_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                sample_ce_q;
  logic                frame_start;
  logic [SAMPLE_W-1:0] active;
  logic [4:0]          k;
  logic [3:0]          bit_idx;

  i2s_sclk_gen #(.DIV(DIV)) u_sclk_gen (
    .clk        (clk),
    .reset      (reset),
    .sclk_o     (sclk),
    .fall_evt_o (fall_evt)
  );

  // Output bits are chosen for the slot being entered, using the freshly
  // latched samples on the frame-start edge so LJ slot 0 carries the new MSB.
  always_comb begin
    slot_d      = slot_q + 6'd1;
    frame_start = fall_evt && (slot_q == 6'd63);
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    if (frame_start) begin
      shift_l_d = mute ? '0 : audio_l;
      shift_r_d = mute ? '0 : audio_r;
    end
    k       = slot_d[4:0];
    active  = slot_d[5] ? shift_r_d : shift_l_d;
    sdata_d = 1'b0;
    bit_idx = 4'd0;
    if (LJ_MODE == LJ_MODE_LJ) begin
      bit_idx = 4'd15 - k[3:0];
      if (!k[4]) sdata_d = active[bit_idx];
    end else begin
      bit_idx = 4'(5'd16 - k);
      if (k >= 5'd1 && k <= 5'd16) sdata_d = active[bit_idx];
    end
    lrclk_d = (LJ_MODE == LJ_MODE_LJ) ? ~slot_d[5] : slot_d[5];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q      <= 6'd63;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      lrclk_q     <= LR_RST;
      sdata_q     <= 1'b0;
      sample_ce_q <= 1'b0;
    end else begin
      sample_ce_q <= frame_start;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      if (fall_evt) begin
        slot_q  <= slot_d;
        lrclk_q <= lrclk_d;
        sdata_q <= sdata_d;
      end
    end
  end

  assign sample_ce = sample_ce_q;
  assign lrclk     = lrclk_q;
  assign sdata     = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: one Philips-mode and one left-justified instance
// share stimulus; each frame is captured slot by slot and compared whole.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] audio_l = 16'h0000;
  logic [15:0] audio_r = 16'h0000;
  logic        mute = 1'b0;
  logic        ce0, sclk0, lr0, sd0;
  logic        ce1, sclk1, lr1, sd1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] cap_sd0, cap_lr0, cap_sd1, cap_lr1;

  localparam logic [63:0] LR_I2S = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] LR_LJ  = 64'hFFFFFFFF_00000000;

  always #5 clk = ~clk;

  i2s_tx #(.CLK_RATE(24576000), .AUDIO_RATE(48000), .LJ_MODE(0)) u_dut_i2s (
    .clk(clk), .reset(reset), .audio_l(audio_l), .audio_r(audio_r), .mute(mute),
    .sample_ce(ce0), .sclk(sclk0), .lrclk(lr0), .sdata(sd0)
  );

  i2s_tx #(.CLK_RATE(24576000), .AUDIO_RATE(48000), .LJ_MODE(1)) u_dut_lj (
    .clk(clk), .reset(reset), .audio_l(audio_l), .audio_r(audio_r), .mute(mute),
    .sample_ce(ce1), .sclk(sclk1), .lrclk(lr1), .sdata(sd1)
  );

  // Leaves the bench 1 time unit after the frame-start edge (slot 0 valid).
  task automatic wait_ce();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (ce0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_ce: sample_ce=0 after 600 cycles, required 1");
    end
  endtask

  task automatic capture_frame(input int chg_slot, input logic [15:0] nl,
                               input logic [15:0] nr, input logic nm);
    for (int s = 0; s < 64; s++) begin
      if (s > 0) begin
        repeat (8) @(posedge clk);
        #1;
      end
      cap_sd0[63-s] = sd0;
      cap_lr0[63-s] = lr0;
      cap_sd1[63-s] = sd1;
      cap_lr1[63-s] = lr1;
      if (s == chg_slot) begin
        audio_l = nl;
        audio_r = nr;
        mute    = nm;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] l, input logic [15:0] r);
    logic [63:0] exp0, exp1;
    exp0 = {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    exp1 = {l, 16'b0, r, 16'b0};
    $display("frame %s: L=%h R=%h i2s_sd=%h lj_sd=%h", name, l, r, cap_sd0, cap_sd1);
    n_cmp++;
    if (cap_sd0 !== exp0) begin
      n_fail++;
      $display("FAIL %s i2s sdata: got %h required %h", name, cap_sd0, exp0);
    end
    n_cmp++;
    if (cap_lr0 !== LR_I2S) begin
      n_fail++;
      $display("FAIL %s i2s lrclk: got %h required %h", name, cap_lr0, LR_I2S);
    end
    n_cmp++;
    if (cap_sd1 !== exp1) begin
      n_fail++;
      $display("FAIL %s lj sdata: got %h required %h", name, cap_sd1, exp1);
    end
    n_cmp++;
    if (cap_lr1 !== LR_LJ) begin
      n_fail++;
      $display("FAIL %s lj lrclk: got %h required %h", name, cap_lr1, LR_LJ);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_cmp++;
    if ({sclk0, sclk1, sd0, sd1, ce0, ce1, lr0, lr1} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL %s outputs: got sclk=%b%b sdata=%b%b ce=%b%b lrclk=%b%b required sclk=00 sdata=00 ce=00 lrclk=01",
               name, sclk0, sclk1, sd0, sd1, ce0, ce1, lr0, lr1);
    end
  endtask

  // Releases reset on a falling clk edge and counts rising edges from 1.
  task automatic check_startup(input string name);
    int first_rise, first_fall, ce_n, ce1_n;
    int ce_e[3];
    logic prev;
    first_rise = -1; first_fall = -1; ce_n = 0; ce1_n = 0; prev = 1'b0;
    ce_e[0] = -1; ce_e[1] = -1; ce_e[2] = -1;
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 1040; e++) begin
      @(posedge clk); #1;
      if (sclk0 && !prev && first_rise < 0) first_rise = e;
      if (!sclk0 && prev && first_fall < 0) first_fall = e;
      prev = sclk0;
      if (ce0) begin
        if (ce_n < 3) ce_e[ce_n] = e;
        ce_n++;
      end
      if (ce1) ce1_n++;
    end
    $display("startup %s: rise=%0d fall=%0d ce=%0d,%0d,%0d count=%0d",
             name, first_rise, first_fall, ce_e[0], ce_e[1], ce_e[2], ce_n);
    n_cmp++;
    if (first_rise != 4) begin
      n_fail++;
      $display("FAIL %s sclk rise edge: got %0d required 4", name, first_rise);
    end
    n_cmp++;
    if (first_fall != 8) begin
      n_fail++;
      $display("FAIL %s sclk fall edge: got %0d required 8", name, first_fall);
    end
    n_cmp++;
    if (ce_e[0] != 8) begin
      n_fail++;
      $display("FAIL %s ce #1 edge: got %0d required 8", name, ce_e[0]);
    end
    n_cmp++;
    if (ce_e[1] != 520) begin
      n_fail++;
      $display("FAIL %s ce #2 edge: got %0d required 520", name, ce_e[1]);
    end
    n_cmp++;
    if (ce_e[2] != 1032) begin
      n_fail++;
      $display("FAIL %s ce #3 edge: got %0d required 1032", name, ce_e[2]);
    end
    n_cmp++;
    if (ce_n != 3 || ce1_n != 3) begin
      n_fail++;
      $display("FAIL %s ce count: got i2s=%0d lj=%0d required 3", name, ce_n, ce1_n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_hold");
    check_startup("reset_release");
  endtask

  task automatic test_pattern();
    audio_l = 16'hA5C3; audio_r = 16'h0001; mute = 1'b0;
    wait_ce();
    capture_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("pattern", 16'hA5C3, 16'h0001);
  endtask

  task automatic test_extremes();
    audio_l = 16'h8000; audio_r = 16'h7FFF;
    wait_ce();
    capture_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("extremes", 16'h8000, 16'h7FFF);
  endtask

  task automatic test_mute();
    audio_l = 16'hFFFF; audio_r = 16'hFFFF; mute = 1'b1;
    wait_ce();
    capture_frame(10, 16'hFFFF, 16'hFFFF, 1'b0);
    check_frame("muted", 16'h0000, 16'h0000);
    wait_ce();
    capture_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("unmuted", 16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_back_to_back();
    audio_l = 16'h5A5A; audio_r = 16'hC3C3;
    wait_ce();
    capture_frame(0, 16'h1234, 16'h1234, 1'b0);
    check_frame("before_change", 16'h5A5A, 16'hC3C3);
    wait_ce();
    capture_frame(-1, 16'h0, 16'h0, 1'b0);
    check_frame("after_change", 16'h1234, 16'h1234);
  endtask

  task automatic test_reset_mid();
    audio_l = 16'hFFFF; audio_r = 16'hFFFF;
    wait_ce();
    repeat (325) @(posedge clk);
    #1;
    n_cmp++;
    if ({sclk0, sd0, sd1, lr0, lr1} !== 5'b11110) begin
      n_fail++;
      $display("FAIL mid_frame slot40: got sclk=%b sdata=%b%b lrclk=%b%b required sclk=1 sdata=11 lrclk=10",
               sclk0, sd0, sd1, lr0, lr1);
    end
    #2 reset = 1'b1;
    #1;
    check_reset_vals("reset_async");
    check_startup("reset_rerelease");
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_extremes();
    test_mute();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
